// File: rtl/mest_pro_rom_arbiter_pkg.sv
// Shared defaults, opcode encoding and the round-robin pick helper for the
// mest_pro instruction-ROM arbiter.
package mest_pro_pkg;

    localparam int DEF_OP_CODE_SIZE     = 4;
    localparam int DEF_INSTRUCTION_SIZE = DEF_OP_CODE_SIZE + 8 + 8 + 8;
    localparam int DEF_ROM_DEPTH        = 256;

    // Upper bound on requesters handled by rr_pick; index width to match.
    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    typedef enum logic [DEF_OP_CODE_SIZE-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JMP  = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BNE  = 4'hA,
        OP_SHL  = 4'hB,
        OP_SHR  = 4'hC,
        OP_MOV  = 4'hD,
        OP_CMP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    // First asserted bit of req at or after ptr, wrapping at n-1 -> 0.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                   input int ptr, input int n);
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_REQ_W-1:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mest_pro_rom_arbiter_if.sv
// Fetch-side bundle between the mest_pro cores and the ROM arbiter.
// addr is flat: slice k*AW +: AW belongs to core k.
interface mest_pro_rom_arbiter_if
    import mest_pro_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AW    = $clog2(DEF_ROM_DEPTH),
    parameter int IW    = DEF_INSTRUCTION_SIZE
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [IW-1:0]       rdata;

    // Cores drive requests and consume grants/returns.
    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    // Arbiter side.
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/mest_pro_rom_arbiter_rr_picker.sv
// Combinational rotating-priority picker: winner is the first request at or
// after i_ptr, wrapping. Produces one-hot, index and any-request flag.
module mest_pro_rr_picker
    import mest_pro_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [PW-1:0]    o_idx,
    output logic             o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    int                 w_pick;

    // Search from the pointer and decode the winner to one-hot.
    always_comb begin
        w_req_ext            = '0;
        w_req_ext[N_REQ-1:0] = i_req;
        w_pick               = rr_pick(w_req_ext, int'(i_ptr), N_REQ);
        o_any                = |i_req;
        o_idx                = PW'(w_pick);
        o_onehot             = '0;
        for (int k = 0; k < N_REQ; k++)
            o_onehot[k] = o_any && (w_pick == k);
    end

endmodule

// File: rtl/mest_pro_rom_arbiter.sv
// Shares one registered-read instruction ROM among N_REQ mest_pro fetch
// ports. Round-robin grant in cycle T, data and one-hot rvalid in T+1.
module mest_pro_rom_arbiter
    import mest_pro_pkg::*;
#(
    parameter int  N_REQ            = 2,
    parameter int  OP_CODE_SIZE     = DEF_OP_CODE_SIZE,
    parameter int  INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
    parameter int  ROM_DEPTH        = DEF_ROM_DEPTH,
    parameter int  CNT_W            = 16,
    localparam int AW               = $clog2(ROM_DEPTH),
    localparam int PW               = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        i_reset_n,
    mest_pro_rom_arbiter_if.slave       fetch,
    output logic [AW-1:0]               o_rom_addr,
    input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
    output logic [CNT_W-1:0]            o_conflict_cnt
);

    logic [N_REQ-1:0] w_onehot;
    logic [PW-1:0]    w_idx;
    logic             w_any;
    logic [PW-1:0]    w_ptr_nxt;
    logic [AW-1:0]    w_addr_sel;
    logic [N_REQ-1:0] w_rvalid;
    logic             w_multi;
    int               w_pop;

    logic [PW-1:0]    r_ptr;
    logic             r_tag_valid;
    logic [PW-1:0]    r_tag_idx;
    logic [CNT_W-1:0] r_cnt;

    // A single requester needs no arbitration: its request is its grant.
    generate
        if (N_REQ == 1) begin : g_single
            assign w_onehot = fetch.req;
            assign w_idx    = '0;
            assign w_any    = fetch.req[0];
        end else begin : g_rr
            mest_pro_rr_picker #(
                .N_REQ (N_REQ),
                .PW    (PW)
            ) u_picker (
                .i_req    (fetch.req),
                .i_ptr    (r_ptr),
                .o_onehot (w_onehot),
                .o_idx    (w_idx),
                .o_any    (w_any)
            );
        end
    endgenerate

    // Winner's successor becomes highest priority next cycle.
    assign w_ptr_nxt = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

    // Address mux: winner's slice, zero when idle.
    always_comb begin
        w_addr_sel = '0;
        for (int k = 0; k < N_REQ; k++)
            if (w_onehot[k]) w_addr_sel = fetch.addr[k*AW +: AW];
    end

    // Count requesters to detect cycles with contention.
    always_comb begin
        w_pop = 0;
        for (int k = 0; k < N_REQ; k++)
            w_pop = w_pop + int'(fetch.req[k]);
        w_multi = (w_pop >= 2);
    end

    // Return tag decode: data on i_rom_data belongs to last cycle's winner.
    always_comb begin
        w_rvalid = '0;
        for (int k = 0; k < N_REQ; k++)
            w_rvalid[k] = r_tag_valid && (r_tag_idx == PW'(k));
    end

    // Grant and ROM address are forced quiet while reset is held.
    assign fetch.gnt    = i_reset_n ? w_onehot : '0;
    assign o_rom_addr   = i_reset_n ? w_addr_sel : '0;
    assign fetch.rvalid = w_rvalid;
    assign fetch.rdata  = i_rom_data;
    assign o_conflict_cnt = r_cnt;

    // Rotate the pointer and remember who owns next cycle's ROM data.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr       <= '0;
            r_tag_valid <= 1'b0;
            r_tag_idx   <= '0;
        end else if (w_any) begin
            r_ptr       <= w_ptr_nxt;
            r_tag_idx   <= w_idx;
            r_tag_valid <= 1'b1;
        end else begin
            r_tag_valid <= 1'b0;
        end
    end

    // Saturating count of contended cycles; holds at all-ones.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_cnt <= '0;
        else if (w_multi && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: tb/tb_mest_pro_rom_arbiter.sv
// Directed table-driven bench for mest_pro_rom_arbiter (2 cores, 4-bit
// conflict counter so saturation is reachable quickly).
module tb_mest_pro_rom_arbiter;
    import mest_pro_pkg::*;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int IW = 28;
    localparam int CW = 4;
    localparam int NV = 24;

    typedef struct packed {
        logic          rst_n;
        logic [NR-1:0] req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [NR-1:0] e_gnt;
        logic [AW-1:0] e_addr;
        logic [NR-1:0] e_rvalid;
        logic [AW-1:0] e_dat;
        logic [CW-1:0] e_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_q;
    logic [CW-1:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl [NV];

    mest_pro_rom_arbiter_if #(.N_REQ(NR), .AW(AW), .IW(IW)) fif ();

    mest_pro_rom_arbiter #(
        .N_REQ            (NR),
        .OP_CODE_SIZE     (4),
        .INSTRUCTION_SIZE (IW),
        .ROM_DEPTH        (256),
        .CNT_W            (CW)
    ) dut (
        .clk            (clk),
        .i_reset_n      (rst_n),
        .fetch          (fif),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_q),
        .o_conflict_cnt (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_word(input logic [7:0] a);
        opcode_e op;
        op = opcode_e'(a[3:0]);
        return {op, a, ~a, a ^ 8'h5A};
    endfunction

    // ROM model: one-cycle registered read.
    always @(posedge clk) rom_q <= rom_word(rom_addr);

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n    = v.rst_n;
        fif.req  = v.req;
        fif.addr = {v.a1, v.a0};
        #1;
        n_vec++;
        if (fif.gnt !== v.e_gnt) begin
            n_err++;
            $display("FAIL %s gnt: got %b want %b", tag, fif.gnt, v.e_gnt);
        end
        if (rom_addr !== v.e_addr) begin
            n_err++;
            $display("FAIL %s rom_addr: got %h want %h", tag, rom_addr, v.e_addr);
        end
        if (fif.rvalid !== v.e_rvalid) begin
            n_err++;
            $display("FAIL %s rvalid: got %b want %b", tag, fif.rvalid, v.e_rvalid);
        end
        if (cnt !== v.e_cnt) begin
            n_err++;
            $display("FAIL %s conflict_cnt: got %0d want %0d", tag, cnt, v.e_cnt);
        end
        if (v.e_rvalid != '0 && fif.rdata !== rom_word(v.e_dat)) begin
            n_err++;
            $display("FAIL %s rdata: got %h want %h", tag, fif.rdata, rom_word(v.e_dat));
        end
    endtask

    initial begin
        vec_t          v;
        logic [NR-1:0] prev_gnt;

        rst_n    = 1'b0;
        fif.req  = '0;
        fif.addr = '0;

        //           rst   req    a0     a1     gnt    addr   rvld   dat    cnt
        // all request through reset, then strict rotation 0,1,0,1
        tbl[0]  = '{1'b0, 2'b11, 8'h10, 8'h20, 2'b00, 8'h00, 2'b00, 8'h00, 4'd0};
        tbl[1]  = '{1'b0, 2'b11, 8'h10, 8'h20, 2'b00, 8'h00, 2'b00, 8'h00, 4'd0};
        tbl[2]  = '{1'b1, 2'b11, 8'h10, 8'h20, 2'b01, 8'h10, 2'b00, 8'h00, 4'd0};
        tbl[3]  = '{1'b1, 2'b11, 8'h10, 8'h20, 2'b10, 8'h20, 2'b01, 8'h10, 4'd1};
        tbl[4]  = '{1'b1, 2'b11, 8'h11, 8'h21, 2'b01, 8'h11, 2'b10, 8'h20, 4'd2};
        tbl[5]  = '{1'b1, 2'b11, 8'h11, 8'h21, 2'b10, 8'h21, 2'b01, 8'h11, 4'd3};
        // core1 alone, addr 5
        tbl[6]  = '{1'b1, 2'b10, 8'h00, 8'h05, 2'b10, 8'h05, 2'b10, 8'h21, 4'd4};
        tbl[7]  = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10, 8'h05, 4'd4};
        // core0 streams 0..3 with no bubbles (grant and return to same core overlap)
        tbl[8]  = '{1'b1, 2'b01, 8'h00, 8'h00, 2'b01, 8'h00, 2'b00, 8'h00, 4'd4};
        tbl[9]  = '{1'b1, 2'b01, 8'h01, 8'h00, 2'b01, 8'h01, 2'b01, 8'h00, 4'd4};
        tbl[10] = '{1'b1, 2'b01, 8'h02, 8'h00, 2'b01, 8'h02, 2'b01, 8'h01, 4'd4};
        tbl[11] = '{1'b1, 2'b01, 8'h03, 8'h00, 2'b01, 8'h03, 2'b01, 8'h02, 4'd4};
        tbl[12] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h03, 4'd4};
        // ptr=1, both request: core1 first, core0 next
        tbl[13] = '{1'b1, 2'b11, 8'h30, 8'h31, 2'b10, 8'h31, 2'b00, 8'h00, 4'd4};
        tbl[14] = '{1'b1, 2'b01, 8'h30, 8'h00, 2'b01, 8'h30, 2'b10, 8'h31, 4'd5};
        tbl[15] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h30, 4'd5};
        // reset right after a grant: tag dropped, ptr back to 0
        tbl[16] = '{1'b1, 2'b10, 8'h00, 8'h44, 2'b10, 8'h44, 2'b00, 8'h00, 4'd5};
        tbl[17] = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 4'd0};
        tbl[18] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 4'd0};
        tbl[19] = '{1'b1, 2'b11, 8'h50, 8'h51, 2'b01, 8'h50, 2'b00, 8'h00, 4'd0};
        tbl[20] = '{1'b1, 2'b10, 8'h00, 8'h51, 2'b10, 8'h51, 2'b01, 8'h50, 4'd1};
        tbl[21] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10, 8'h51, 4'd1};
        // top address passes unchanged
        tbl[22] = '{1'b1, 2'b01, 8'hFF, 8'h00, 2'b01, 8'hFF, 2'b00, 8'h00, 4'd1};
        tbl[23] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01, 8'hFF, 4'd1};

        for (int i = 0; i < NV; i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Hold both requests 20 cycles: rotation continues from ptr=1 and
        // the 4-bit counter climbs from 1 and sticks at 15.
        prev_gnt = '0;
        for (int i = 0; i < 20; i++) begin
            v.rst_n    = 1'b1;
            v.req      = 2'b11;
            v.a0       = 8'h60;
            v.a1       = 8'h61;
            v.e_gnt    = (i % 2 == 0) ? 2'b10 : 2'b01;
            v.e_addr   = v.e_gnt[1] ? 8'h61 : 8'h60;
            v.e_rvalid = (i == 0) ? 2'b00 : prev_gnt;
            v.e_dat    = prev_gnt[1] ? 8'h61 : 8'h60;
            v.e_cnt    = (i + 1 > 15) ? 4'd15 : CW'(i + 1);
            apply(v, $sformatf("sat%0d", i));
            prev_gnt = v.e_gnt;
        end

        v = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, prev_gnt, 8'h60, 4'd15};
        apply(v, "sat_tail0");
        v = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 4'd15};
        apply(v, "sat_tail1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
